// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port ram between NUM_REQ requesters.
// Each grant runs the full ram txs/txe handshake before the requester is acknowledged.
module ram_arbiter #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 64,
    parameter int unsigned NUM_REQ   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_txs,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_value,
    output logic [NUM_REQ-1:0]             req_txe,
    output logic [WORD_SIZE-1:0]           resp_out,
    output logic                           resp_err,
    output logic                           mem_txs,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_SIZE-1:0]           mem_addr,
    output logic [WORD_SIZE-1:0]           mem_value,
    input  logic                           mem_txe,
    input  logic [WORD_SIZE-1:0]           mem_out,
    input  logic                           mem_err
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StMemReq, StMemRel, StAck} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      last_q, last_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]   req_txe_q, req_txe_d;
    logic [WORD_SIZE-1:0] resp_out_q, resp_out_d;
    logic                 resp_err_q, resp_err_d;
    logic                 mem_txs_q, mem_txs_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_value_q, mem_value_d;

    logic [ADDR_SIZE-1:0] addr_arr  [NUM_REQ];
    logic [WORD_SIZE-1:0] value_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
        assign value_arr[gi] = req_value[gi*WORD_SIZE +: WORD_SIZE];
    end

    logic            found;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] sel;
    int unsigned     idx;

    // Scan starts just after the last served requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sel    = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IdxW'(idx);
            if (!found && req_txs[sel] && !req_txe_q[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= IdxW'(NUM_REQ - 1);
            grant_q     <= '0;
            req_txe_q   <= '0;
            resp_out_q  <= '0;
            resp_err_q  <= 1'b0;
            mem_txs_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_value_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            req_txe_q   <= req_txe_d;
            resp_out_q  <= resp_out_d;
            resp_err_q  <= resp_err_d;
            mem_txs_q   <= mem_txs_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_value_q <= mem_value_d;
        end
    end

    // Idle waits for mem_txe low so a handshake orphaned by reset can drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!mem_txe && found) state_d = StMemReq;
            StMemReq: if (mem_txe) state_d = StMemRel;
            StMemRel: if (!mem_txe) state_d = StAck;
            StAck:    if (!req_txs[grant_q]) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        grant_d     = grant_q;
        req_txe_d   = req_txe_q;
        resp_out_d  = resp_out_q;
        resp_err_d  = resp_err_q;
        mem_txs_d   = mem_txs_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_value_d = mem_value_q;
        unique case (state_q)
            StIdle: begin
                if (!mem_txe && found) begin
                    grant_d     = winner;
                    mem_txs_d   = 1'b1;
                    mem_read_d  = req_read[winner];
                    mem_write_d = req_write[winner];
                    mem_addr_d  = addr_arr[winner];
                    mem_value_d = value_arr[winner];
                end
            end
            StMemReq: begin
                if (mem_txe) begin
                    resp_out_d = mem_out;
                    resp_err_d = mem_err;
                    mem_txs_d  = 1'b0;
                end
            end
            StMemRel: begin
                if (!mem_txe) req_txe_d[grant_q] = 1'b1;
            end
            StAck: begin
                if (!req_txs[grant_q]) begin
                    req_txe_d = '0;
                    last_d    = grant_q;
                end
            end
            default: ;
        endcase
    end

    assign req_txe   = req_txe_q;
    assign resp_out  = resp_out_q;
    assign resp_err  = resp_err_q;
    assign mem_txs   = mem_txs_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_value = mem_value_q;

endmodule
